pampy_fetch_unit: RTL
=====================

Name: pampy_fetch_unit

Overview:
Parametrised instruction front-end for the pamPy stack processor, succeeding the fixed PC/instruction/argument register block. It fetches instruction words from a synchronous instruction memory and splits them into opcode and argument. It folds EXTENDED_ARG prefixes into a wide argument and presents one decoded instruction at a time to the execute stage over a valid/ready handshake. Taken jumps (absolute or relative) are applied on the consuming handshake.

Parameters:
DATA_WIDTH, 8, opcode and per-word argument width
ADDR_WIDTH, 12, instruction word address / PC width
INSTRUCTION_WIDTH, 16, memory word width; opcode = upper DATA_WIDTH bits, argument = lower DATA_WIDTH bits
ARG_WIDTH, 24, accumulated argument width; multiple of DATA_WIDTH, at least DATA_WIDTH
EXT_ARG_OPCODE, 144, opcode value treated as an EXTENDED_ARG prefix
RESET_PC, 0, PC loaded on start

Ports:
general_clk  in  1  clock; all logic on rising edge
general_reset  in  1  asynchronous, active-low reset
start  in  1  leave IDLE and begin fetching at RESET_PC
halt  in  1  stop fetching and return to IDLE
imem_en  out  1  memory read strobe
imem_addr  out  ADDR_WIDTH  read address
imem_rdata  in  INSTRUCTION_WIDTH  read data, valid the cycle after imem_en
instr_valid  out  1  decoded instruction available
instr_ready  in  1  execute stage accepts instruction
instr_opcode  out  DATA_WIDTH  opcode
instr_arg  out  ARG_WIDTH  accumulated argument, zero-extended
instr_pc  out  ADDR_WIDTH  address of the non-prefix instruction word
jump_en  in  1  taken jump; sampled only on the handshake cycle
jump_rel  in  1  1 = relative jump, 0 = absolute jump
jump_target  in  ADDR_WIDTH  absolute target or unsigned forward offset
ext_overflow  out  1  sticky flag: too many prefixes
busy  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; pc=RESET_PC; arg_acc=0; prefix count=0. Outputs imem_en, instr_valid, ext_overflow and busy are 0. imem_addr, instr_opcode, instr_arg and instr_pc are 0.
- FSM states: IDLE, REQ, RESP, PRESENT.
- IDLE: start=1 and halt=0 -> REQ. On that transition: pc=RESET_PC, arg_acc=0, count=0, ext_overflow=0.
- REQ: imem_en=1, imem_addr=pc for exactly this cycle; -> RESP.
- RESP: capture imem_rdata.
  - If opcode==EXT_ARG_OPCODE: arg_acc=(arg_acc|arg)<<DATA_WIDTH, truncated to ARG_WIDTH. count+1. pc+1. -> REQ.
  - If count was already ARG_WIDTH/DATA_WIDTH-1 when the prefix arrives: set ext_overflow. High bits are discarded and fetching continues.
  - Otherwise: register opcode; instr_arg=arg_acc|arg; instr_pc=pc; pc=pc+1; clear arg_acc and count; -> PRESENT.
- PRESENT: instr_valid=1.
  - instr_opcode, instr_arg and instr_pc hold stable until instr_valid&&instr_ready.
  - On handshake: -> REQ.
  - If jump_en=1 on the handshake: pc = jump_rel ? instr_pc+1+jump_target : jump_target.
  - jump_en without instr_ready is ignored.
- Minimum throughput is one instruction per 3 cycles. Each prefix adds 2 cycles.
- PC arithmetic is modulo 2^ADDR_WIDTH. pc at all-ones +1 wraps to 0; relative targets wrap the same way.
- halt=1 in any non-IDLE state -> IDLE next cycle.
  - instr_valid drops.
  - arg_acc and count are cleared. pc and ext_overflow are kept.
  - A handshake in the same cycle as halt still counts as consumed, and a jump on it still updates pc.
  - halt has priority over start.
- Reset asserted mid-fetch: immediate return to reset values. The discarded read is not presented.
- Outputs are registered; there is no combinational path from instr_ready or jump_* to any output.

Test Plan:
- Reset with imem words {0x6401, 0x1700}, start pulse -> imem_addr 0 then 1. Instructions presented: (op 0x64, arg 0x000001, pc 0) then (op 0x17, arg 0, pc 1). instr_valid first rises 3 cycles after start.
- Prefix words {0x9001, 0x9002, 0x6403} -> single instruction op 0x64, arg 0x010203, pc 2, ext_overflow=0. Three prefixes then an opcode -> arg is the low 24 bits, ext_overflow=1 until the next start.
- instr_ready held low 10 cycles in PRESENT -> outputs stable, imem_en=0 throughout; the next fetch starts the cycle after ready.
- Handshake at pc 5 with jump_en=1, jump_rel=0, target 0x020 -> next imem_addr 0x020. Same case with jump_rel=1, target 3 -> next imem_addr 9. Relative jump from instr_pc 0xFFE with offset 4 -> imem_addr 0x003.
- halt in RESP halfway through an extended-arg sequence -> IDLE, no instr_valid. After restart the first instruction's arg excludes the stale prefix.
- Reset asserted during PRESENT -> instr_valid=0 immediately (asynchronous), busy=0, and no fetch occurs until start.

Source files
------------

// File: rtl/pampy_fetch_if.sv
// pampy_fetch_if: bundles the fetch unit's instruction-memory read port and
// its decoded-instruction handshake towards the execute stage.
//   master : the fetch unit (drives imem_en/imem_addr and the instr_* outputs)
//   slave  : memory + execute stage (drives imem_rdata, instr_ready, jump_*)
// Signals:
//   imem_en, imem_addr, imem_rdata            synchronous memory read port
//   instr_valid, instr_ready                  decoded-instruction handshake
//   instr_opcode, instr_arg, instr_pc         decoded instruction payload
//   jump_en, jump_rel, jump_target            jump request, taken on handshake
interface pampy_fetch_if #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int ARG_WIDTH         = 24
);
  logic                         imem_en;
  logic [ADDR_WIDTH-1:0]        imem_addr;
  logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
  logic                         instr_valid;
  logic                         instr_ready;
  logic [DATA_WIDTH-1:0]        instr_opcode;
  logic [ARG_WIDTH-1:0]         instr_arg;
  logic [ADDR_WIDTH-1:0]        instr_pc;
  logic                         jump_en;
  logic                         jump_rel;
  logic [ADDR_WIDTH-1:0]        jump_target;

  modport master (
    output imem_en, imem_addr, instr_valid, instr_opcode, instr_arg, instr_pc,
    input  imem_rdata, instr_ready, jump_en, jump_rel, jump_target
  );

  modport slave (
    input  imem_en, imem_addr, instr_valid, instr_opcode, instr_arg, instr_pc,
    output imem_rdata, instr_ready, jump_en, jump_rel, jump_target
  );
endinterface

// File: rtl/pampy_fetch_unit.sv
// pampy_fetch_unit: instruction front-end of the pamPy stack processor.
// Fetches words from a synchronous instruction memory, folds EXTENDED_ARG
// prefixes into a wide argument and presents one decoded instruction at a
// time over a valid/ready handshake. Jumps are applied on the handshake.
// Ports:
//   general_clk    clock, rising edge
//   general_reset  asynchronous active-low reset
//   start          leave IDLE and begin fetching at RESET_PC
//   halt           stop fetching and return to IDLE (beats start)
//   ext_overflow   sticky: more prefixes than fit in ARG_WIDTH
//   busy           unit is not IDLE
//   bus            memory port + instruction handshake (master side)
module pampy_fetch_unit #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 12,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int ARG_WIDTH         = 24,
  parameter int EXT_ARG_OPCODE    = 144,
  parameter int RESET_PC          = 0
) (
  input  logic             general_clk,
  input  logic             general_reset,
  input  logic             start,
  input  logic             halt,
  output logic             ext_overflow,
  output logic             busy,
  pampy_fetch_if.master    bus
);

  localparam int ARG_WORDS = ARG_WIDTH / DATA_WIDTH;
  localparam int CNT_W     = $clog2(ARG_WORDS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2,
    PRESENT = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [ADDR_WIDTH-1:0]   pc_r, pc_s;
  logic [ARG_WIDTH-1:0]    acc_r, acc_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic                    ovf_r, ovf_s;
  logic                    en_r, en_s;
  logic [ADDR_WIDTH-1:0]   addr_r, addr_s;
  logic                    valid_r, valid_s;
  logic [DATA_WIDTH-1:0]   op_r, op_s;
  logic [ARG_WIDTH-1:0]    arg_r, arg_s;
  logic [ADDR_WIDTH-1:0]   ipc_r, ipc_s;
  logic                    busy_r, busy_s;

  logic [DATA_WIDTH-1:0]   rd_op_s;
  logic [DATA_WIDTH-1:0]   rd_arg_s;
  logic [ARG_WIDTH-1:0]    merged_s;
  logic                    is_ext_s;

  assign rd_op_s  = bus.imem_rdata[INSTRUCTION_WIDTH-1 -: DATA_WIDTH];
  assign rd_arg_s = bus.imem_rdata[DATA_WIDTH-1:0];
  assign merged_s = acc_r | ARG_WIDTH'(rd_arg_s);
  assign is_ext_s = (rd_op_s == DATA_WIDTH'(EXT_ARG_OPCODE));

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_s = state_r;
    pc_s    = pc_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    ovf_s   = ovf_r;
    op_s    = op_r;
    arg_s   = arg_r;
    ipc_s   = ipc_r;

    case (state_r)
      IDLE: begin
        if (start && !halt) begin
          state_s = REQ;
          pc_s    = ADDR_WIDTH'(RESET_PC);
          acc_s   = '0;
          cnt_s   = '0;
          ovf_s   = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (halt) begin
          state_s = IDLE;
          acc_s   = '0;
          cnt_s   = '0;
        end else begin
          state_s = RESP;
        end
      end
      RESP: begin
        if (halt) begin
          // The word being returned is dropped; pc still names it.
          state_s = IDLE;
          acc_s   = '0;
          cnt_s   = '0;
        end else if (is_ext_s) begin
          acc_s   = ARG_WIDTH'(merged_s << DATA_WIDTH);
          pc_s    = pc_r + ADDR_WIDTH'(1);
          state_s = REQ;
          // Saturate the count once full; further prefixes only lose high bits.
          if (cnt_r == CNT_W'(ARG_WORDS - 1)) begin
            ovf_s = 1'b1;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          op_s    = rd_op_s;
          arg_s   = merged_s;
          ipc_s   = pc_r;
          pc_s    = pc_r + ADDR_WIDTH'(1);
          acc_s   = '0;
          cnt_s   = '0;
          state_s = PRESENT;
        end
      end
      PRESENT: begin
        // A handshake is honoured even when halt arrives in the same cycle.
        if (bus.instr_ready) begin
          state_s = REQ;
          if (bus.jump_en) begin
            if (bus.jump_rel) begin
              pc_s = ipc_r + ADDR_WIDTH'(1) + bus.jump_target;
            end else begin
              pc_s = bus.jump_target;
            end
          end else begin
            pc_s = pc_r;
          end
        end else begin
          state_s = PRESENT;
        end
        if (halt) begin
          state_s = IDLE;
          acc_s   = '0;
          cnt_s   = '0;
        end else begin
          acc_s   = acc_s;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    en_s    = (state_s == REQ);
    addr_s  = (state_s == REQ) ? pc_s : addr_r;
    valid_s = (state_s == PRESENT);
    busy_s  = (state_s != IDLE);
  end

  // State and output registers; outputs are the registered next values.
  always_ff @(posedge general_clk or negedge general_reset) begin
    if (!general_reset) begin
      state_r <= IDLE;
      pc_r    <= ADDR_WIDTH'(RESET_PC);
      acc_r   <= '0;
      cnt_r   <= '0;
      ovf_r   <= 1'b0;
      en_r    <= 1'b0;
      addr_r  <= '0;
      valid_r <= 1'b0;
      op_r    <= '0;
      arg_r   <= '0;
      ipc_r   <= '0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      pc_r    <= pc_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
      ovf_r   <= ovf_s;
      en_r    <= en_s;
      addr_r  <= addr_s;
      valid_r <= valid_s;
      op_r    <= op_s;
      arg_r   <= arg_s;
      ipc_r   <= ipc_s;
      busy_r  <= busy_s;
    end
  end

  assign bus.imem_en      = en_r;
  assign bus.imem_addr    = addr_r;
  assign bus.instr_valid  = valid_r;
  assign bus.instr_opcode = op_r;
  assign bus.instr_arg    = arg_r;
  assign bus.instr_pc     = ipc_r;
  assign ext_overflow     = ovf_r;
  assign busy             = busy_r;

endmodule
